// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: redirect record,
// exception codes, FSM states and the per-depth stall vectors.
package pipeline_ctrl_pkg;

   typedef struct packed {
      logic        en;
      logic [31:0] addr;
   } jump_t;

   localparam logic JUMP_ENABLE  = 1'b1;
   localparam logic JUMP_DISABLE = 1'b0;

   typedef enum logic [2:0] {
      EXC_INT     = 3'd0,
      EXC_SYSCALL = 3'd1,
      EXC_BREAK   = 3'd2,
      EXC_RI      = 3'd3,
      EXC_OVF     = 3'd4,
      EXC_ERET    = 3'd5
   } exc_type_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } ctrl_state_t;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   // Deepest requester wins: it freezes itself and everything upstream.
   function automatic logic [5:0] stall_merge(input logic if_req, input logic id_req,
                                              input logic ex_req, input logic mem_req);
      if (mem_req)     return STALL_MEM;
      else if (ex_req) return STALL_EX;
      else if (id_req) return STALL_ID;
      else if (if_req) return STALL_IF;
      else             return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage-facing signal bundle of the pipeline sequencer; the core side is
// the master, the sequencer is the slave.
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic        if_stallreq_i;
   logic        id_stallreq_i;
   logic        ex_stallreq_i;
   logic        mem_stallreq_i;
   logic        exc_valid_i;
   exc_type_t   exc_type_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   jump_t       ctrl_jump_o;
   logic        wdog_o;
   logic [31:0] perf_stall_cycles_o;
   logic [31:0] perf_flush_count_o;

   modport master (
      output if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i,
      output exc_valid_i, exc_type_i, cp0_epc_i,
      input  stall_o, flush_o, ctrl_jump_o, wdog_o,
      input  perf_stall_cycles_o, perf_flush_count_o
   );

   modport slave (
      input  if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i,
      input  exc_valid_i, exc_type_i, cp0_epc_i,
      output stall_o, flush_o, ctrl_jump_o, wdog_o,
      output perf_stall_cycles_o, perf_flush_count_o
   );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stage stalls, turns MEM exceptions/ERET into a
// one-cycle flush plus redirect, and keeps a stall watchdog and perf counters.
//   state | meaning
//   RUN   | normal flow; stalls honoured, exceptions accepted when MEM not stalled
//   FLUSH | one cycle: flush_o=1, redirect to latched target, stalls/exceptions ignored
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
   parameter int          WDOG_CYCLES = 1024,
   parameter bit          PERF_EN     = 1'b1
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);

   localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

   ctrl_state_t state_q;
   logic        flush_q;
   jump_t       jump_q;
   logic        wdog_q;

   logic [5:0]  stall;
   logic        stall_any;
   logic        accept;
   logic [31:0] target;
   logic [15:0] wdog_cnt;

   always_comb begin
      stall = STALL_NONE;
      if (!rst && (state_q == RUN))
         stall = stall_merge(bus.if_stallreq_i, bus.id_stallreq_i,
                             bus.ex_stallreq_i, bus.mem_stallreq_i);
   end

   assign stall_any = |stall;
   // A stalled MEM still owns its instruction, so the exception waits for it.
   assign accept    = (state_q == RUN) && bus.exc_valid_i && !bus.mem_stallreq_i;
   assign target    = (bus.exc_type_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         flush_q <= 1'b0;
         jump_q  <= '{en: JUMP_DISABLE, addr: 32'h0};
      end else begin
         case (state_q)
            RUN: begin
               if (accept) begin
                  state_q <= FLUSH;
                  flush_q <= 1'b1;
                  jump_q  <= '{en: JUMP_ENABLE, addr: target};
               end
            end
            FLUSH: begin
               state_q <= RUN;
               flush_q <= 1'b0;
               jump_q  <= '{en: JUMP_DISABLE, addr: 32'h0};
            end
            default: begin
               state_q <= RUN;
               flush_q <= 1'b0;
               jump_q  <= '{en: JUMP_DISABLE, addr: 32'h0};
            end
         endcase
      end
   end

   sat_counter #(.WIDTH(16)) u_wdog_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_any),
      .clr (!stall_any),
      .cnt (wdog_cnt)
   );

   // Trips on the WDOG_CYCLES-th consecutive stalled edge and stays set.
   always_ff @(posedge clk) begin
      if (rst)
         wdog_q <= 1'b0;
      else if (stall_any && (wdog_cnt >= WDOG_LAST))
         wdog_q <= 1'b1;
   end

   generate
      if (PERF_EN) begin : g_perf
         logic [31:0] stall_cycles, flush_count;

         sat_counter #(.WIDTH(32)) u_stall_cycles (
            .clk (clk),
            .rst (rst),
            .inc (stall_any),
            .clr (1'b0),
            .cnt (stall_cycles)
         );

         sat_counter #(.WIDTH(32)) u_flush_count (
            .clk (clk),
            .rst (rst),
            .inc (accept),
            .clr (1'b0),
            .cnt (flush_count)
         );

         assign bus.perf_stall_cycles_o = stall_cycles;
         assign bus.perf_flush_count_o  = flush_count;
      end else begin : g_no_perf
         assign bus.perf_stall_cycles_o = 32'h0;
         assign bus.perf_flush_count_o  = 32'h0;
      end
   endgenerate

   assign bus.stall_o     = stall;
   assign bus.flush_o     = flush_q;
   assign bus.ctrl_jump_o = jump_q;
   assign bus.wdog_o      = wdog_q;

endmodule
